// File: rtl/ascii_pair_parser.sv
// Parses "<digits><blank><digits>\n" ASCII lines into (data_stream1, data_stream2) valid pulses.
// Optional build macro ASCII_PARSER_SAT_EN clamps field overflow to all-ones instead of wrapping.
module ascii_pair_parser #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_stream1,
    output logic [WIDTH-1:0] data_stream2,
    output logic             valid,
    output logic             done,
    output logic [WIDTH-1:0] pair_count,
    output logic             bad_line
);

    localparam logic [3:0] S_LINE_START = 4'd0;
    localparam logic [3:0] S_FIELD1     = 4'd1;
    localparam logic [3:0] S_SEP        = 4'd2;
    localparam logic [3:0] S_FIELD2     = 4'd3;
    localparam logic [3:0] S_TRAIL      = 4'd4;
    localparam logic [3:0] S_SKIP       = 4'd5;
    localparam logic [3:0] S_EMIT       = 4'd6;
    localparam logic [3:0] S_FINISH     = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [WIDTH-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic             last_q, last_d;
    logic             bad_set;
    logic             take, is_digit, is_blank, is_eol, is_cr, is_junk;
    logic [3:0]       dval;

    // Decimal shift-in of one digit; wraps or clamps depending on build.
    function automatic logic [WIDTH-1:0] mac(input logic [WIDTH-1:0] acc, input logic [3:0] d);
`ifdef ASCII_PARSER_SAT_EN
        logic [WIDTH+3:0] wide;
        wide = ({4'd0, acc} * (WIDTH+4)'(10)) + (WIDTH+4)'(d);
        mac  = (wide[WIDTH+3:WIDTH] != 4'd0) ? '1 : wide[WIDTH-1:0];
`else
        mac = (acc * WIDTH'(10)) + WIDTH'(d);
`endif
    endfunction

    assign take     = in_valid && in_ready;
    assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign is_blank = (in_byte == 8'h20) || (in_byte == 8'h09);
    assign is_eol   = (in_byte == 8'h0A);
    assign is_cr    = (in_byte == 8'h0D);
    assign is_junk  = !(is_digit || is_blank || is_eol || is_cr);
    assign dval     = in_byte[3:0];

    // Next-state, accumulator and malformed-line decode
    always_comb begin
        state_d = state_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        last_d  = last_q;
        bad_set = 1'b0;
        case (state_q)
            S_EMIT: begin
                state_d = last_q ? S_FINISH : S_LINE_START;
                last_d  = 1'b0;
            end
            S_FINISH: state_d = S_DONE;
            S_DONE:   state_d = S_DONE;
            default: begin
                if (take && !is_cr) begin
                    case (state_q)
                        S_LINE_START: begin
                            if (is_digit) begin
                                acc1_d  = WIDTH'(dval);
                                state_d = S_FIELD1;
                            end else if (is_junk) begin
                                state_d = S_SKIP;
                                bad_set = 1'b1;
                            end
                        end
                        S_FIELD1: begin
                            if (is_digit) begin
                                acc1_d = mac(acc1_q, dval);
                            end else if (is_blank) begin
                                state_d = S_SEP;
                            end else begin
                                state_d = is_eol ? S_LINE_START : S_SKIP;
                                bad_set = 1'b1;
                            end
                        end
                        S_SEP: begin
                            if (is_digit) begin
                                acc2_d  = WIDTH'(dval);
                                state_d = S_FIELD2;
                            end else if (!is_blank) begin
                                state_d = is_eol ? S_LINE_START : S_SKIP;
                                bad_set = 1'b1;
                            end
                        end
                        S_FIELD2: begin
                            if (is_digit) begin
                                acc2_d = mac(acc2_q, dval);
                            end else if (is_blank) begin
                                state_d = S_TRAIL;
                            end else if (is_eol) begin
                                state_d = S_EMIT;
                            end else begin
                                state_d = S_SKIP;
                                bad_set = 1'b1;
                            end
                        end
                        S_TRAIL: begin
                            if (is_eol) begin
                                state_d = S_EMIT;
                            end else if (!is_blank) begin
                                state_d = S_SKIP;
                                bad_set = 1'b1;
                            end
                        end
                        default: begin
                            if (is_eol) state_d = S_LINE_START;
                        end
                    endcase
                end
                // Final byte: emit a completed second field, otherwise drop the partial line
                if (take && in_last) begin
                    if ((state_q == S_FIELD2 || state_q == S_TRAIL) && !is_junk) begin
                        state_d = S_EMIT;
                        last_d  = 1'b1;
                        bad_set = 1'b0;
                    end else begin
                        state_d = S_FINISH;
                        bad_set = bad_set || (state_q inside {S_FIELD1, S_SEP, S_SKIP});
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LINE_START;
            acc1_q       <= '0;
            acc2_q       <= '0;
            last_q       <= 1'b0;
            in_ready     <= 1'b0;
            data_stream1 <= '0;
            data_stream2 <= '0;
            valid        <= 1'b0;
            done         <= 1'b0;
            pair_count   <= '0;
            bad_line     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc1_q   <= acc1_d;
            acc2_q   <= acc2_d;
            last_q   <= last_d;
            in_ready <= state_d inside {S_LINE_START, S_FIELD1, S_SEP, S_FIELD2, S_TRAIL, S_SKIP};
            valid    <= (state_d == S_EMIT);
            done     <= (state_d == S_FINISH);
            if (state_d == S_EMIT) begin
                data_stream1 <= acc1_d;
                data_stream2 <= acc2_d;
                pair_count   <= pair_count + WIDTH'(1);
            end
            if (bad_set) bad_line <= 1'b1;
        end
    end

endmodule

// File: doc/ascii_pair_parser.md
# ascii_pair_parser

Front-end stage that turns the raw puzzle input, a stream of ASCII bytes, into the two-column integer stream consumed by the list-distance core. Each line of the form `<digits><whitespace><digits>\n` becomes one `valid` pulse carrying both values on `data_stream1`/`data_stream2`. After the last line, a one-cycle `done` pulse follows. The block sits between the byte source (testbench file reader or UART RX) and the core's `data_stream1/2, valid, done` inputs.

## Interface
- `WIDTH`, 32: width of each parsed value and of `pair_count`.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_byte`  in  8  ASCII byte from source.
- `in_valid`  in  1  `in_byte` is valid.
- `in_last`  in  1  qualifies the final byte of the file; sampled only on an accepted byte.
- `in_ready`  out  1  block accepts a byte this cycle; a byte transfers when `in_valid && in_ready`.
- `data_stream1`  out  WIDTH  left-column value; held stable between pulses.
- `data_stream2`  out  WIDTH  right-column value; held stable between pulses.
- `valid`  out  1  one-cycle pulse, one per well-formed line.
- `done`  out  1  one-cycle pulse after the final pair.
- `pair_count`  out  WIDTH  number of `valid` pulses issued since reset.
- `bad_line`  out  1  sticky; set when any line was discarded as malformed.

## Operation
- Byte classes:
  - digit: `0x30`–`0x39`.
  - blank: space `0x20` or tab `0x09`.
  - EOL: `0x0A`.
  - CR `0x0D` is ignored in every state.
  - Any other byte is junk.
- States:
  - LINE_START: blank or EOL ignored (blank lines produce nothing). A digit loads acc1 and goes to FIELD1. Junk goes to SKIP.
  - FIELD1: digit updates acc1 = acc1*10 + d. Blank goes to SEP. EOL or junk goes to SKIP (EOL discards the line and returns to LINE_START).
  - SEP: blank ignored. A digit loads acc2 and goes to FIELD2. EOL or junk is malformed.
  - FIELD2: digit updates acc2. Blank goes to TRAIL. EOL goes to EMIT. Junk goes to SKIP.
  - TRAIL: blank ignored. EOL goes to EMIT. Digit or junk goes to SKIP.
  - SKIP: all bytes discarded until EOL, then LINE_START.
  - EMIT: one cycle. Drives `data_stream1` = acc1 and `data_stream2` = acc2, asserts `valid`, increments `pair_count`, then returns to LINE_START (or FINISH if the line ended on `in_last`).
  - FINISH: one cycle; asserts `done`, then goes to DONE.
  - DONE: absorbing until reset.
- Every transition into SKIP sets `bad_line`.
- `in_last` handling:
  - `in_last` on a byte that completes a line (EOL) goes to EMIT and then FINISH.
  - `in_last` on a digit or blank inside FIELD2 or TRAIL is treated as an implicit EOL: EMIT, then FINISH.
  - `in_last` in any other state discards the partial line. This sets `bad_line` if the partial line was in FIELD1, SEP or SKIP. The block then goes straight to FINISH.
- Arithmetic: the multiply-add is performed modulo 2^WIDTH (wraps) unless the saturation feature is compiled in.
- `in_ready` = 1 in LINE_START, FIELD1, SEP, FIELD2, TRAIL and SKIP. `in_ready` = 0 in EMIT, FINISH and DONE.

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after release; `data_stream1`=0, `data_stream2`=0, `valid`=0, `done`=0, `pair_count`=0, `bad_line`=0; state is LINE_START.
- Latency: `valid` is high in the cycle after the terminating EOL is accepted.
- `done` is high exactly one cycle after the final `valid`, or one cycle after the `in_last` byte if no pair is emitted. `valid` and `done` are never high together.
- Each line stalls the source for one cycle (EMIT), so the throughput is one byte per cycle otherwise.
- Reset asserted mid-line or mid-EMIT clears all state immediately; no pulse is emitted.

## Configuration
- `ASCII_PARSER_SAT_EN`:
  - Defined: a field whose value would exceed 2^WIDTH−1 clamps to all-ones, and the line is still emitted. Digits arriving after saturation keep the value at all-ones.
  - Undefined: the value wraps modulo 2^WIDTH with no flag.

## Test plan
- "3   4\n4   3\n" with `in_last` on the final `\n` -> `valid` pulses carrying (3,4) then (4,3); `done` one cycle after the second pulse; `pair_count`=2; `bad_line`=0.
- "12\t34\r\n\n 56 78  " with `in_last` on the final space -> pairs (12,34) and (56,78); blank line ignored; `done` follows.
- "7 x9\n5 6\n" -> (5,6) only; `bad_line`=1; `pair_count`=1.
- "4294967296 1\n" (WIDTH=32): with `ASCII_PARSER_SAT_EN` defined -> (0xFFFFFFFF,1); without it -> (0,1).
- `in_valid` held high continuously -> `in_ready` drops for exactly the EMIT cycle of each line; no byte is lost or duplicated.
- Reset pulse after "12 3" with no EOL yet, then "1 2\n" with `in_last` -> single pair (1,2); `pair_count`=1.
